// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and port IDs for the divider arbiter
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_CALC  = 2'd1,
    DIV_FIXUP = 2'd2,
    DIV_RESP  = 2'd3
  } div_state_e;

  localparam logic DIV_PORT_CPU = 1'b0;
  localparam logic DIV_PORT_GTE = 1'b1;

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - unsigned restoring divider, one quotient bit per step
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // quo_q starts as the dividend and shifts out its MSB into the partial
  // remainder while quotient bits shift in from the bottom
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - two-port arbiter, sign handling and FSM around div_core
module div_arbiter
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_signed,
  input  logic [WIDTH-1:0] req0_dividend,
  input  logic [WIDTH-1:0] req0_divisor,
  input  logic             req0_abort,
  output logic             rsp0_valid,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_signed,
  input  logic [WIDTH-1:0] req1_dividend,
  input  logic [WIDTH-1:0] req1_divisor,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_div0,
  output logic             busy
);

  div_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic             sgn_q, sgn_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div0_q, div0_d;

  logic             v0, v1, grant, accept;
  logic             sel_signed, sel_dvd_neg, sel_dvs_neg;
  logic [WIDTH-1:0] sel_dvd, sel_dvs, dvd_mag, dvs_mag;
  logic             core_load, core_step;
  logic [WIDTH-1:0] core_quot, core_rem;

  // A flushing port 0 never competes, so port 1 can win the same cycle
  always_comb begin
    v0          = req0_valid && !req0_abort;
    v1          = req1_valid;
    grant       = DIV_PORT_CPU;
    if (v0 && v1)  grant = ~last_grant_q;
    else if (v1)   grant = DIV_PORT_GTE;
    accept      = (state_q == DIV_IDLE) && (v0 || v1);
    req0_ready  = accept && (grant == DIV_PORT_CPU);
    req1_ready  = accept && (grant == DIV_PORT_GTE);
    sel_signed  = grant ? req1_signed   : req0_signed;
    sel_dvd     = grant ? req1_dividend : req0_dividend;
    sel_dvs     = grant ? req1_divisor  : req0_divisor;
    sel_dvd_neg = sel_signed && sel_dvd[WIDTH-1];
    sel_dvs_neg = sel_signed && sel_dvs[WIDTH-1];
    dvd_mag     = sel_dvd_neg ? -sel_dvd : sel_dvd;
    dvs_mag     = sel_dvs_neg ? -sel_dvs : sel_dvs;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    sgn_d        = sgn_q;
    dvd_neg_d    = dvd_neg_q;
    dvs_neg_d    = dvs_neg_q;
    cnt_d        = cnt_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    div0_d       = div0_q;
    core_load    = 1'b0;
    core_step    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          owner_d      = grant;
          last_grant_d = grant;
          sgn_d        = sel_signed;
          dvd_neg_d    = sel_dvd_neg;
          dvs_neg_d    = sel_dvs_neg;
          cnt_d        = '0;
          if (sel_dvs == '0) begin
            quot_d  = '1;
            rem_d   = sel_dvd;
            div0_d  = 1'b1;
            state_d = DIV_RESP;
          end else begin
            div0_d    = 1'b0;
            core_load = 1'b1;
            state_d   = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        core_step = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DIV_FIXUP;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      DIV_FIXUP: begin
        quot_d  = (sgn_q && (dvd_neg_q != dvs_neg_q)) ? -core_quot : core_quot;
        rem_d   = (sgn_q && dvd_neg_q) ? -core_rem : core_rem;
        state_d = DIV_RESP;
      end
      DIV_RESP: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if ((state_q != DIV_IDLE) && req0_abort && (owner_q == DIV_PORT_CPU))
      state_d = DIV_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= DIV_IDLE;
      last_grant_q <= DIV_PORT_GTE;
      owner_q      <= DIV_PORT_CPU;
      sgn_q        <= 1'b0;
      dvd_neg_q    <= 1'b0;
      dvs_neg_q    <= 1'b0;
      cnt_q        <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      div0_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      sgn_q        <= sgn_d;
      dvd_neg_q    <= dvd_neg_d;
      dvs_neg_q    <= dvs_neg_d;
      cnt_q        <= cnt_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      div0_q       <= div0_d;
    end
  end

  div_core #(.WIDTH(WIDTH)) u_core (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (core_load),
    .step      (core_step),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (core_quot),
    .remainder (core_rem)
  );

  assign rsp0_valid    = (state_q == DIV_RESP) && (owner_q == DIV_PORT_CPU) && !req0_abort;
  assign rsp1_valid    = (state_q == DIV_RESP) && (owner_q == DIV_PORT_GTE);
  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
  assign rsp_div0      = div0_q;
  assign busy          = (state_q != DIV_IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed vector bench for div_arbiter
module tb_div_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_signed, req0_abort, rsp0_valid;
  logic [31:0] req0_dividend, req0_divisor;
  logic        req1_valid, req1_ready, req1_signed, rsp1_valid;
  logic [31:0] req1_dividend, req1_divisor;
  logic [31:0] rsp_quotient, rsp_remainder;
  logic        rsp_div0, busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          port;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          d0;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  div_arbiter #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_signed(req0_signed),
    .req0_dividend(req0_dividend), .req0_divisor(req0_divisor), .req0_abort(req0_abort),
    .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_signed(req1_signed),
    .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
    .rsp1_valid(rsp1_valid),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_div0(rsp_div0), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int port, input bit v, input bit s, input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req0_valid = v; req0_signed = s; req0_dividend = a; req0_divisor = b;
    end else begin
      req1_valid = v; req1_signed = s; req1_dividend = a; req1_divisor = b;
    end
  endtask

  function automatic logic rdy(input int port);
    return (port == 0) ? req0_ready : req1_ready;
  endfunction

  // Called at a sample point; returns the cycle of the response or -1
  task automatic wait_rsp(input int port, input int budget, output int t);
    logic other;
    other = 1'b0;
    t = -1;
    for (int k = 0; k < budget; k++) begin
      if ((port == 0) ? rsp1_valid : rsp0_valid) other = 1'b1;
      if ((port == 0) ? rsp0_valid : rsp1_valid) begin
        t = cyc;
        break;
      end
      @(negedge clock); #1;
    end
    chk("other_port_quiet", other, 1'b0);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    logic ok;
    int   t_acc, t_rsp;
    v = vecs[idx];
    ok = 1'b0;
    @(negedge clock);
    drive(v.port, 1'b1, v.sgn, v.a, v.b);
    #1;
    for (int k = 0; k < 50; k++) begin
      if (rdy(v.port)) begin ok = 1'b1; break; end
      @(negedge clock); #1;
    end
    chk($sformatf("v%0d_accept", idx), ok, 1'b1);
    t_acc = cyc;
    @(negedge clock);
    drive(v.port, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    wait_rsp(v.port, 60, t_rsp);
    chk($sformatf("v%0d_latency", idx), t_rsp - t_acc, v.lat);
    chk($sformatf("v%0d_quot", idx), rsp_quotient, v.q);
    chk($sformatf("v%0d_rem", idx), rsp_remainder, v.r);
    chk($sformatf("v%0d_div0", idx), rsp_div0, v.d0);
    @(negedge clock); #1;
    chk($sformatf("v%0d_idle", idx), {busy, rsp0_valid, rsp1_valid}, 3'b000);
  endtask

  initial begin
    int t0, t1, t_acc;

    vecs[0] = '{0, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
    vecs[1] = '{1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34};
    vecs[2] = '{1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34};
    vecs[3] = '{0, 1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 1};
    vecs[4] = '{0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34};
    vecs[5] = '{1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34};
    vecs[6] = '{0, 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 34};
    vecs[7] = '{1, 1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 34};
    vecs[8] = '{0, 1'b0, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  32'h0000_FFFF,  1'b0, 34};
    vecs[9] = '{1, 1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1};

    reset_n = 1'b0;
    req0_abort = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clock);
    #1;
    chk("reset_flags", {busy, rsp0_valid, rsp1_valid, rsp_div0, req0_ready, req1_ready}, 6'b0);
    chk("reset_quot", rsp_quotient, 32'd0);
    chk("reset_rem", rsp_remainder, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Tie after reset: port 0 first, then port 1 takes the next tie
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 32'd100, 32'd7);
    drive(1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    #1;
    chk("tie1_ready0", req0_ready, 1'b1);
    chk("tie1_ready1", req1_ready, 1'b0);
    t_acc = cyc;
    @(negedge clock); #1;
    chk("tie1_busy", busy, 1'b1);
    wait_rsp(0, 60, t0);
    chk("tie1_latency", t0 - t_acc, 34);
    chk("tie1_quot", rsp_quotient, 32'd14);
    chk("tie1_rem", rsp_remainder, 32'd2);
    @(negedge clock); #1;
    chk("tie2_ready1", req1_ready, 1'b1);
    chk("tie2_ready0", req0_ready, 1'b0);
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    wait_rsp(1, 60, t1);
    chk("tie_gap", t1 - t0, 35);
    chk("tie2_quot", rsp_quotient, 32'hFFFF_FFFD);
    chk("tie2_rem", rsp_remainder, 32'hFFFF_FFFF);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Port 0 flushed in its tenth CALC cycle while port 1 waits
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 32'd100, 32'd7);
    #1;
    chk("abort_accept0", req0_ready, 1'b1);
    t_acc = cyc;
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b1, 1'b0, 32'd1000, 32'd10);
    for (int k = 2; k <= 10; k++) @(negedge clock);
    req0_abort = 1'b1;
    #1;
    chk("abort_calc_cycle", cyc - t_acc, 10);
    chk("abort_busy_during", busy, 1'b1);
    chk("abort_ready1_during", req1_ready, 1'b0);
    @(negedge clock);
    req0_abort = 1'b0;
    #1;
    chk("abort_busy_after", busy, 1'b0);
    chk("abort_ready1_after", req1_ready, 1'b1);
    chk("abort_no_rsp0", rsp0_valid, 1'b0);
    t_acc = cyc;
    @(negedge clock);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    wait_rsp(1, 60, t1);
    chk("abort_p1_latency", t1 - t_acc, 34);
    chk("abort_p1_quot", rsp_quotient, 32'd100);
    chk("abort_p1_rem", rsp_remainder, 32'd0);

    // Abort in IDLE only removes port 0 from arbitration
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 32'd5, 32'd1);
    drive(1, 1'b1, 1'b0, 32'd9, 32'd3);
    req0_abort = 1'b1;
    #1;
    chk("idle_abort_ready0", req0_ready, 1'b0);
    chk("idle_abort_ready1", req1_ready, 1'b1);
    t_acc = cyc;
    @(negedge clock);
    req0_abort = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    wait_rsp(1, 60, t1);
    chk("idle_abort_latency", t1 - t_acc, 34);
    chk("idle_abort_quot", rsp_quotient, 32'd3);

    // Asynchronous reset mid-CALC, then the next tie goes to port 0 again
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 32'd100, 32'd7);
    #1;
    chk("rst_accept0", req0_ready, 1'b1);
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (5) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_flags", {busy, rsp0_valid, rsp1_valid, rsp_div0}, 4'b0);
    chk("rst_async_quot", rsp_quotient, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 32'd100, 32'd7);
    drive(1, 1'b1, 1'b0, 32'd50, 32'd5);
    #1;
    chk("rst_tie_ready0", req0_ready, 1'b1);
    chk("rst_tie_ready1", req1_ready, 1'b0);
    t_acc = cyc;
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    wait_rsp(0, 60, t0);
    chk("rst_tie_latency", t0 - t_acc, 34);
    chk("rst_tie_quot", rsp_quotient, 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
